sram_fill_seq: RTL
==================

SRAM_FILL_SEQ -- requirements
Module: sram_fill_seq

Interface
- REQ-001 Parameters, one per line (name, default, meaning):
  - AW, 5, RAM address width (depth 2**AW).
  - DW, 4, RAM data width.
  - RD_LAT, 2, read-port latency in clk cycles from rd_addr to rd_q.
- REQ-002 Ports, one per line (name, direction, width, meaning):
  - clk, in, 1, clock.
  - rstn, in, 1, reset: synchronous, active-low.
  - start, in, 1, single-cycle fill request.
  - tick, in, 1, write-pacing enable.
  - mode, in, 2, pattern select.
  - seed, in, DW, pattern seed.
  - wr_en, out, 1, RAM write enable.
  - wr_addr, out, AW, RAM write address.
  - wr_data, out, DW, RAM write data.
  - rd_addr, out, AW, RAM read address.
  - rd_q, in, DW, RAM read data.
  - busy, out, 1, sequence in progress.
  - done, out, 1, one-cycle completion pulse.
  - err, out, 1, verify mismatch flag.
  - err_addr, out, AW, address of first mismatch.

Function
- REQ-003 FSM states SHALL be IDLE, WRITE, VERIFY and FINISH; all outputs registered.
- REQ-004 IDLE: start=1 SHALL capture mode/seed, clear idx, err and err_addr, and enter WRITE next cycle; busy=1 from that cycle.
- REQ-005 start while busy=1 SHALL be ignored; captured mode/seed SHALL NOT change mid-sequence.
- REQ-006 WRITE: on each cycle with tick=1, wr_en SHALL be 1 for exactly that cycle.
  - wr_addr=idx and wr_data=pattern(idx); idx then increments.
  - With tick=0, wr_en=0 and idx holds.
- REQ-007 Pattern (all arithmetic mod 2**DW, idx truncated to DW):
  - mode 0: seed.
  - mode 1: seed+idx.
  - mode 2: idx.
  - mode 3: bitwise NOT idx.
- REQ-008 After the write at idx=2**AW-1, idx SHALL wrap to 0 and FSM SHALL enter VERIFY (macro defined) or FINISH (macro undefined).
- REQ-009 VERIFY: rd_addr SHALL advance 0..2**AW-1, one address per cycle, independent of tick.
  - rd_q SHALL be compared RD_LAT cycles after each address with pattern(address).
- REQ-010 First mismatch SHALL set err=1 and latch err_addr; later mismatches SHALL NOT change err_addr.
  - The scan SHALL always complete all addresses.
- REQ-011 After the last compare, FSM SHALL enter FINISH.
- REQ-012 FINISH SHALL assert done=1 for one cycle, drop busy in that same cycle and return to IDLE.
  - err/err_addr SHALL hold until the next accepted start.
- REQ-013 start coincident with the done cycle SHALL be ignored; it is accepted from the following cycle.
- REQ-014 wr_en SHALL be 0 in every state other than WRITE; rd_addr SHALL hold its last value outside VERIFY.

Reset
- REQ-015 rstn=0 at a clk edge SHALL force, on that edge, regardless of state, including mid-WRITE or mid-VERIFY:
  - FSM=IDLE and idx=0.
  - wr_en=0, wr_addr=0, wr_data=0, rd_addr=0.
  - busy=0, done=0, err=0, err_addr=0.
- REQ-016 An interrupted sequence SHALL NOT resume; a new start is required.

Configuration
- REQ-017 Macro SRAM_FILL_VERIFY_EN:
  - Defined: VERIFY state, compare pipeline and err logic are compiled in.
  - Undefined: WRITE goes directly to FINISH, rd_addr is tied 0, and err/err_addr are tied 0.

Verification
- REQ-018 mode=1, seed=4'hA, tick=1 always, ideal RAM model -> 32 writes with wr_data A,B,..,F,0,..; done pulses once; err=0.
- REQ-019 mode=3, tick high every 4th cycle -> wr_en exactly 32 single-cycle pulses 4 cycles apart; addr 5 written 4'hA.
- REQ-020 macro on, RAM model corrupts addr 7 and addr 20 -> err=1, err_addr=7 at done.
- REQ-021 rstn low for one cycle after the 10th write -> all outputs 0 next cycle; no further wr_en until new start; a fresh fill then completes normally.
- REQ-022 start pulsed again during WRITE and on the done cycle -> both ignored; exactly one done per accepted start.
- REQ-023 macro off, mode=2 -> done 1 cycle after the last write; rd_addr=0 and err=0 throughout.

Source files
------------

// File: rtl/sram_fill_seq.sv
// RAM fill sequencer: writes a mode-selected pattern to every address, paced by tick.
// Define SRAM_FILL_VERIFY_EN to add a read-back pass that flags the first mismatching address.
module sram_fill_seq #(
   parameter int AW     = 5,
   parameter int DW     = 4,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic          tick,
   input  logic [1:0]    mode,
   input  logic [DW-1:0] seed,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_q,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW-1:0] err_addr
);
   typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FINISH} state_t;

   state_t        state_reg, state_next;
   logic [AW-1:0] idx_reg;
   logic          wrap_reg;
   logic [1:0]    mode_reg;
   logic [DW-1:0] seed_reg;
   logic          wr_en_reg;
   logic [AW-1:0] wr_addr_reg;
   logic [DW-1:0] wr_data_reg;
   logic          busy_reg;
   logic          done_reg;
   logic          accept;
   logic          write_end;
   logic          verify_end;

   function automatic logic [DW-1:0] pattern(input logic [1:0] m, input logic [DW-1:0] s,
                                             input logic [AW-1:0] a);
      logic [DW-1:0] a_dw;
      a_dw = DW'(a);
      case (m)
         2'd0:    pattern = s;
         2'd1:    pattern = s + a_dw;
         2'd2:    pattern = a_dw;
         default: pattern = ~a_dw;
      endcase
   endfunction

   // FINISH is the done cycle, so a start seen there is ignored by construction.
   assign accept    = (state_reg == IDLE) && start;
   assign write_end = (state_reg == WRITE) && wrap_reg;

   always_ff @(posedge clk) begin
      if (!rstn) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = WRITE;
         WRITE: begin
            if (wrap_reg) begin
`ifdef SRAM_FILL_VERIFY_EN
               state_next = VERIFY;
`else
               state_next = FINISH;
`endif
            end
         end
         VERIFY:  if (verify_end) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // wrap_reg holds WRITE for one cycle after the last write so wr_en never overlaps another state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         idx_reg     <= '0;
         wrap_reg    <= 1'b0;
         mode_reg    <= '0;
         seed_reg    <= '0;
         wr_en_reg   <= 1'b0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         wr_en_reg <= 1'b0;
         busy_reg  <= (state_next == WRITE) || (state_next == VERIFY);
         done_reg  <= (state_next == FINISH);
         if (accept) begin
            mode_reg <= mode;
            seed_reg <= seed;
            idx_reg  <= '0;
            wrap_reg <= 1'b0;
         end else if ((state_reg == WRITE) && !wrap_reg && tick) begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= idx_reg;
            wr_data_reg <= pattern(mode_reg, seed_reg, idx_reg);
            idx_reg     <= idx_reg + AW'(1);
            if (idx_reg == '1) wrap_reg <= 1'b1;
         end
      end
   end

   assign wr_en   = wr_en_reg;
   assign wr_addr = wr_addr_reg;
   assign wr_data = wr_data_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;

`ifdef SRAM_FILL_VERIFY_EN
   logic          scan_reg;
   logic [AW-1:0] rd_addr_reg;
   logic          err_reg;
   logic [AW-1:0] err_addr_reg;
   logic          pipe_vld  [RD_LAT];
   logic [AW-1:0] pipe_addr [RD_LAT];
   logic          cmp_vld;
   logic [AW-1:0] cmp_addr;

   // Tail of the pipe lines up with rd_q for the address issued RD_LAT cycles earlier.
   assign cmp_vld    = pipe_vld[RD_LAT-1];
   assign cmp_addr   = pipe_addr[RD_LAT-1];
   assign verify_end = cmp_vld && (cmp_addr == '1);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_vld[i]  <= 1'b0;
            pipe_addr[i] <= '0;
         end
      end else begin
         pipe_vld[0]  <= (state_reg == VERIFY) && scan_reg;
         pipe_addr[0] <= rd_addr_reg;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         scan_reg     <= 1'b0;
         rd_addr_reg  <= '0;
         err_reg      <= 1'b0;
         err_addr_reg <= '0;
      end else begin
         if (write_end) begin
            scan_reg    <= 1'b1;
            rd_addr_reg <= '0;
         end else if ((state_reg == VERIFY) && scan_reg) begin
            if (rd_addr_reg == '1) scan_reg <= 1'b0;
            else                   rd_addr_reg <= rd_addr_reg + AW'(1);
         end
         if (accept) begin
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
         end else if (cmp_vld && !err_reg && (rd_q != pattern(mode_reg, seed_reg, cmp_addr))) begin
            err_reg      <= 1'b1;
            err_addr_reg <= cmp_addr;
         end
      end
   end

   assign rd_addr  = rd_addr_reg;
   assign err      = err_reg;
   assign err_addr = err_addr_reg;
`else
   logic unused_rd_q;
   assign unused_rd_q = ^rd_q;
   assign verify_end  = 1'b0;
   assign rd_addr     = '0;
   assign err         = 1'b0;
   assign err_addr    = '0;
`endif
endmodule
